// File: rtl/fifo_flags.sv
// fifo_flags: single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, overflow/underflow pulses and an
// optional first-word-fall-through read port.
//
// Ports:
//   clk          rising-edge clock
//   rstn         synchronous active-low reset
//   wr_en        write request, data_in is the word to store
//   rd_en        read request (standard) or pop acknowledge (FWFT)
//   data_out     read data, qualified by valid
//   full/empty   count == DEPTH / count == 0
//   almost_full  count >= AF_THRESH
//   almost_empty count <= AE_THRESH
//   count        occupancy, 0..DEPTH
//   overflow     one-cycle pulse after a rejected write
//   underflow    one-cycle pulse after a read of an empty FIFO
module fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      wr_en,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic                      rd_en,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      valid,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         cnt;
    logic                  wa;
    logic                  ra;
    logic                  ovf_q;
    logic                  udf_q;

    // All flags decode the count register only.
    assign full         = (cnt == CW'(DEPTH));
    assign empty        = (cnt == '0);
    assign almost_full  = (cnt >= CW'(AF_THRESH));
    assign almost_empty = (cnt <= CW'(AE_THRESH));
    assign count        = cnt;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // A full FIFO still takes a write when a read frees a slot this cycle.
    // An empty FIFO never serves a read, even with a concurrent write.
    assign ra = rd_en && !empty;
    assign wa = wr_en && (!full || ra);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            if (wa) wr_ptr <= wr_ptr + 1'b1;
            if (ra) rd_ptr <= rd_ptr + 1'b1;
            unique case ({wa, ra})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            ovf_q <= wr_en && !wa;
            udf_q <= rd_en && empty;
        end
    end

    // Storage is not reset. When full, a same-slot read sees the old word
    // because the read samples before this write lands.
    always_ff @(posedge clk) begin
        if (rstn && wa) mem[wr_ptr] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = mem[rd_ptr];
            assign valid    = !empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dq;
            logic                  vq;

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    dq <= '0;
                    vq <= 1'b0;
                end else begin
                    vq <= ra;
                    if (ra) dq <= mem[rd_ptr];
                end
            end

            assign data_out = dq;
            assign valid    = vq;
        end
    endgenerate

endmodule

// File: doc/fifo_flags.md
Name: fifo_flags

Overview:
Parametrised synchronous single-clock FIFO, the successor to the basic FIFO. It adds programmable almost-full and almost-empty thresholds, an occupancy count, and overflow/underflow error pulses. A FWFT parameter selects between a registered-read mode and a first-word-fall-through mode. It is used as the general buffering primitive between streaming stages in the same clock domain.

Parameters:
DATA_WIDTH, 8, width of each stored word
DEPTH, 16, number of entries; must be a power of two and >= 2
AF_THRESH, 14, almost_full asserts when count >= AF_THRESH (range 1..DEPTH)
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (range 0..DEPTH-1)
FWFT, 0, 0 = registered-read (standard) mode; 1 = first-word-fall-through mode

Ports:
clk  input  1  rising-edge clock, the only clock
rstn  input  1  reset, synchronous, active-low
wr_en  input  1  write request
data_in  input  DATA_WIDTH  write data
rd_en  input  1  read request (standard mode) or pop (FWFT mode)
data_out  output  DATA_WIDTH  read data
valid  output  1  data_out qualifier
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  one-cycle pulse: write rejected
underflow  output  1  one-cycle pulse: read rejected

Behaviour:
- Reset:
  - Applied when rstn=0 at a clk edge.
  - Pointers = 0, count = 0, data_out = 0, valid = 0, overflow = 0, underflow = 0.
  - Resulting flags: empty = 1, full = 0, almost_empty = 1, almost_full = (AF_THRESH == 0, never).
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored words. Any wr_en/rd_en in the reset cycle is ignored and produces no error pulse.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 by natural overflow.
- Occupancy: a separate count register is the sole source of all flags. Flags are combinational decodes of count, so they are valid in the cycle after the updating edge.
- Write accept (wa): wr_en && (!full || ra).
  - A write to a full FIFO is accepted when a read is accepted in the same cycle.
- Read accept (ra): rd_en && !empty.
  - A read of an empty FIFO is never accepted, even with a simultaneous write.
- Count update per edge:
  - wa only: +1
  - ra only: -1
  - wa && ra: unchanged
  - count never exceeds DEPTH and never wraps below 0.
- Error pulses:
  - overflow is registered: = wr_en && !wa, high for exactly the following cycle.
  - underflow is registered: = rd_en && empty.
  - Back-to-back rejected requests produce continuous high.
- Standard mode (FWFT=0):
  - On ra, data_out <= mem[rd_ptr] and valid <= 1 at the same edge, so data appears one cycle after rd_en.
  - valid <= 0 on any edge without ra.
  - data_out holds its last value when no read occurs.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] combinationally; valid = !empty.
  - rd_en acts as a pop acknowledge.
  - A word written into an empty FIFO appears on data_out with valid=1 the cycle after the write edge.
  - When empty, data_out is don't-care and valid = 0.
- Ordering: strict FIFO order across pointer wrap in both modes.
- Same-address case: write and read of the same entry in one cycle can only occur when count == DEPTH. The read returns the old (stored) word and the write then replaces it.

Test Plan:
- Reset then idle (DEPTH=16, AE=2, AF=14) -> empty=1, almost_empty=1, full=0, count=0, valid=0, overflow=0, underflow=0.
- Fill (FWFT=0): write 0x00..0x0F on 16 consecutive cycles -> count reaches 16, almost_full rises after 14th write, full after 16th. A 17th write of 0xAA -> overflow pulses one cycle, count stays 16, 0xAA is never read.
- Drain (FWFT=0): rd_en for 16 cycles -> data_out = 0x00..0x0F, each one cycle after its rd_en with valid=1. empty is set after the 16th read. A further rd_en -> underflow pulse, valid=0, data_out holds 0x0F.
- Simultaneous at boundaries:
  - When full, wr_en+rd_en with data 0x55 -> count stays 16, no overflow, 0x55 is read out 16 reads later.
  - When empty, wr_en+rd_en -> write taken, count = 1, underflow pulses.
- FWFT=1: write 0x3C into an empty FIFO -> next cycle valid=1, data_out=0x3C with no rd_en. rd_en for one cycle -> valid=0, empty=1.
- Wrap and mid-op reset: run 40 interleaved random writes/reads and check order against a model queue. Assert rstn=0 with count=5 -> next cycle count=0, empty=1, valid=0, and the old data is never returned.
